// File: rtl/video_arith_pkg.sv
// rtl/video_arith_pkg.sv - shared types and constants for the video arithmetic arbiter
package video_arith_pkg;
    localparam int A_W = 24;
    localparam int B_W = 12;

    localparam logic OP_DIV = 1'b0;
    localparam logic OP_MUL = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_RUN,
        ST_DONE
    } state_t;
endpackage

// File: rtl/sys_udiv.sv
// rtl/sys_udiv.sv - sequential restoring unsigned divider, one quotient bit per cycle
module sys_udiv #(
    parameter int AW = 24,
    parameter int BW = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] a,
    input  logic [BW-1:0] b,
    output logic          run,
    output logic [AW-1:0] quot
);
    localparam int CW = $clog2(AW);

    logic          run_q, run_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] quot_q, quot_d;
    logic [BW-1:0] rem_q, rem_d;
    logic [BW-1:0] div_q, div_d;
    logic [BW:0]   shifted;
    logic [BW+1:0] trial;

    always_comb begin
        run_d   = run_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        div_d   = div_q;
        shifted = {rem_q, quot_q[AW-1]};
        trial   = {1'b0, shifted} - {2'b00, div_q};
        if (!run_q && start) begin
            run_d  = 1'b1;
            cnt_d  = '0;
            quot_d = a;
            rem_d  = '0;
            div_d  = b;
        end else if (run_q) begin
            // Remainder stays below the divisor, so the trial difference fits in BW bits.
            if (!trial[BW+1]) begin
                rem_d  = trial[BW-1:0];
                quot_d = {quot_q[AW-2:0], 1'b1};
            end else begin
                rem_d  = shifted[BW-1:0];
                quot_d = {quot_q[AW-2:0], 1'b0};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(AW-1)) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_q  <= 1'b0;
            cnt_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            div_q  <= '0;
        end else begin
            run_q  <= run_d;
            cnt_q  <= cnt_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            div_q  <= div_d;
        end
    end

    assign run  = run_q;
    assign quot = quot_q;
endmodule

// File: rtl/sys_umul.sv
// rtl/sys_umul.sv - sequential shift-add unsigned multiplier, one multiplier bit per cycle
module sys_umul #(
    parameter int AW = 12,
    parameter int BW = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [AW-1:0]    a,
    input  logic [BW-1:0]    b,
    output logic             run,
    output logic [AW+BW-1:0] prod
);
    localparam int CW = $clog2(BW);

    logic             run_q, run_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    mcand_q, mcand_d;
    logic [AW+BW-1:0] prod_q, prod_d;
    logic [AW:0]      sum;

    always_comb begin
        run_d   = run_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        // Upper half accumulates while the multiplier shifts out of the lower half.
        sum     = {1'b0, prod_q[AW+BW-1:BW]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        if (!run_q && start) begin
            run_d   = 1'b1;
            cnt_d   = '0;
            mcand_d = a;
            prod_d  = {{AW{1'b0}}, b};
        end else if (run_q) begin
            prod_d = {sum, prod_q[BW-1:1]};
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(BW-1)) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_q   <= 1'b0;
            cnt_q   <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
        end else begin
            run_q   <= run_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
        end
    end

    assign run  = run_q;
    assign prod = prod_q;
endmodule

// File: rtl/video_arith_rr.sv
// rtl/video_arith_rr.sv - round-robin pick: first active request at or above the pointer, wrapping
module video_arith_rr #(
    parameter int NREQ  = 2,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [PTR_W-1:0] idx,
    output logic             valid
);
    int j;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = (int'(ptr) + i) % NREQ;
            if (!valid && req[j]) begin
                valid    = 1'b1;
                grant[j] = 1'b1;
                idx      = PTR_W'(j);
            end
        end
    end
endmodule

// File: rtl/video_arith_arb.sv
// rtl/video_arith_arb.sv - arbitrates requesters onto one shared divider and one shared multiplier
// Define VIDEO_ARITH_DIVZERO_EN to answer divide-by-zero with 24'hFFFFFF without starting the divider.
module video_arith_arb
    import video_arith_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int PTR_W = 2
) (
    input  logic               CLK_VIDEO,
    input  logic               RESET,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    op,
    input  logic [NREQ*A_W-1:0] arg_a,
    input  logic [NREQ*B_W-1:0] arg_b,
    output logic [NREQ-1:0]    ack,
    output logic [NREQ-1:0]    done,
    output logic [A_W-1:0]     res,
    output logic               busy
);
    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d, win_q, win_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic               op_q, op_d, dz_q, dz_d;
    logic [A_W-1:0]     a_q, a_d;
    logic [B_W-1:0]     b_q, b_d;
    logic [NREQ-1:0]    ack_q, ack_d, done_q, done_d;
    logic [A_W-1:0]     res_q, res_d;

    logic [NREQ-1:0]    grant;
    logic [PTR_W-1:0]   win_idx;
    logic               win_valid;
    logic               sel_op;
    logic [A_W-1:0]     sel_a;
    logic [B_W-1:0]     sel_b;
    logic               div_start, mul_start, div_run, mul_run, unit_run;
    logic [A_W-1:0]     div_quot;
    logic [2*B_W-1:0]   mul_prod;

    video_arith_rr #(.NREQ(NREQ), .PTR_W(PTR_W)) u_rr (
        .req   (req),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (win_idx),
        .valid (win_valid)
    );

    sys_udiv #(.AW(A_W), .BW(B_W)) u_div (
        .clk   (CLK_VIDEO),
        .reset (RESET),
        .start (div_start),
        .a     (a_q),
        .b     (b_q),
        .run   (div_run),
        .quot  (div_quot)
    );

    sys_umul #(.AW(B_W), .BW(B_W)) u_mul (
        .clk   (CLK_VIDEO),
        .reset (RESET),
        .start (mul_start),
        .a     (a_q[B_W-1:0]),
        .b     (b_q),
        .run   (mul_run),
        .prod  (mul_prod)
    );

    always_comb begin
        sel_op = |(op & grant);
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a = arg_a[i*A_W +: A_W];
                sel_b = arg_b[i*B_W +: B_W];
            end
        end
    end

    assign div_start = (state_q == ST_START) && (op_q == OP_DIV);
    assign mul_start = (state_q == ST_START) && (op_q == OP_MUL);
    assign unit_run  = (op_q == OP_MUL) ? mul_run : div_run;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        gnt_d   = gnt_q;
        op_d    = op_q;
        dz_d    = dz_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        ack_d   = '0;
        done_d  = '0;
        case (state_q)
            ST_IDLE: begin
                // Both units must be quiet so a unit still draining after reset is never restarted.
                if (win_valid && !div_run && !mul_run) begin
                    win_d = win_idx;
                    gnt_d = grant;
                    op_d  = sel_op;
                    a_d   = sel_a;
                    b_d   = sel_b;
                    ack_d = grant;
`ifdef VIDEO_ARITH_DIVZERO_EN
                    dz_d  = (sel_op == OP_DIV) && (sel_b == '0);
`else
                    dz_d  = 1'b0;
`endif
                    state_d = dz_d ? ST_DONE : ST_START;
                end
            end
            ST_START: state_d = ST_RUN;
            ST_RUN: begin
                if (!unit_run) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (dz_q) begin
                    res_d = '1;
                end else if (op_q == OP_MUL) begin
                    res_d = mul_prod;
                end else begin
                    res_d = div_quot;
                end
                done_d  = gnt_q;
                ptr_d   = (win_q == PTR_W'(NREQ-1)) ? '0 : win_q + PTR_W'(1);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_VIDEO) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            gnt_q   <= '0;
            op_q    <= 1'b0;
            dz_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            ack_q   <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            gnt_q   <= gnt_d;
            op_q    <= op_d;
            dz_q    <= dz_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
        end
    end

    assign ack  = ack_q;
    assign done = done_q;
    assign res  = res_q;
    assign busy = (state_q != ST_IDLE);
endmodule

// File: tb/tb_video_arith_arb.sv
// tb/tb_video_arith_arb.sv - self-checking bench: vector table, scoreboard and arbitration corner cases
module tb_video_arith_arb;
    localparam int NREQ = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req, op, ack, done;
    logic [NREQ*24-1:0] arg_a;
    logic [NREQ*12-1:0] arg_b;
    logic [23:0]       res;
    logic              busy;

    int n_cmp  = 0;
    int n_fail = 0;
    int ack_seen [NREQ];
    int div_start_cnt = 0;

    always #5 clk = ~clk;

    video_arith_arb #(.NREQ(NREQ), .PTR_W(2)) dut (
        .CLK_VIDEO (clk),
        .RESET     (rst),
        .req       (req),
        .op        (op),
        .arg_a     (arg_a),
        .arg_b     (arg_b),
        .ack       (ack),
        .done      (done),
        .res       (res),
        .busy      (busy)
    );

    typedef struct {
        int          idx;
        bit          chk;
        logic [23:0] res;
    } exp_t;

    typedef struct {
        int          idx;
        bit          op;
        logic [23:0] a;
        logic [11:0] b;
        logic [23:0] exp;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, want);
        end
    endtask

    // Scoreboard and protocol monitor.
    always @(negedge clk) begin
        exp_t e;
        if (dut.div_start) div_start_cnt++;
        for (int i = 0; i < NREQ; i++) if (ack[i]) ack_seen[i]++;
        if (ack != 0 || done != 0) check("ack_done_onehot", 32'($onehot({ack, done})), 1);
        if (done != 0) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 0);
            end else begin
                e = sb.pop_front();
                check("done_idx", 32'(done), 32'(1) << e.idx);
                if (e.chk) check("res", 32'(res), 32'(e.res));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input int idx, input bit o, input logic [23:0] a, input logic [11:0] b);
        op[idx]           = o;
        arg_a[idx*24 +: 24] = a;
        arg_b[idx*12 +: 12] = b;
        req[idx]          = 1'b1;
    endtask

    task automatic push(input int idx, input bit chk, input logic [23:0] r);
        exp_t e;
        e.idx = idx;
        e.chk = chk;
        e.res = r;
        sb.push_back(e);
    endtask

    task automatic wait_done(input int max, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (done == 0 && cycles < max);
        check("done_seen", 32'(done != 0), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    int cyc;
    int order[4];
    int nack;
    int ack0_before;
    int dstart_before;
    int done_cnt;

    initial begin
        rst   = 1'b1;
        req   = '0;
        op    = '0;
        arg_a = '0;
        arg_b = '0;
        for (int i = 0; i < NREQ; i++) ack_seen[i] = 0;

        vecs[0] = '{0, 1'b1, 24'd720,     12'd3,    24'd2160};
        vecs[1] = '{1, 1'b0, 24'd1080,    12'd240,  24'd4};
        vecs[2] = '{0, 1'b0, 24'hFFFFFF,  12'd4095, 24'd4097};
        vecs[3] = '{1, 1'b1, 24'h123FFF,  12'hFFF,  24'hFFE001};
        vecs[4] = '{0, 1'b0, 24'd100,     12'd200,  24'd0};
        vecs[5] = '{1, 1'b1, 24'd4095,    12'd1,    24'd4095};
        vecs[6] = '{0, 1'b0, 24'hFFFFFF,  12'd1,    24'hFFFFFF};
        vecs[7] = '{1, 1'b1, 24'd1000,    12'd1000, 24'd1000000};

        repeat (3) @(negedge clk);
        check("rst_ack",  32'(ack),  0);
        check("rst_done", 32'(done), 0);
        check("rst_res",  32'(res),  0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 8; k++) begin
            drive(vecs[k].idx, vecs[k].op, vecs[k].a, vecs[k].b);
            @(negedge clk);
            check("ack_latency", 32'(ack), 32'(1) << vecs[k].idx);
            check("busy_after_ack", 32'(busy), 1);
            req[vecs[k].idx] = 1'b0;
            push(vecs[k].idx, 1'b1, vecs[k].exp);
            arg_a[vecs[k].idx*24 +: 24] = ~vecs[k].a;
            wait_done(100, cyc);
            check("busy_at_done", 32'(busy), 0);
            repeat (3) @(negedge clk);
            check("res_held", 32'(res), 32'(vecs[k].exp));
        end

        // Contention from a fresh pointer: grants must alternate.
        do_reset();
        drive(0, 1'b1, 24'd10,   12'd20);
        drive(1, 1'b0, 24'd1000, 12'd10);
        nack = 0;
        cyc  = 0;
        while (nack < 4 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (ack != 0) begin
                order[nack] = ack[1] ? 1 : 0;
                push(order[nack], 1'b1, ack[1] ? 24'd100 : 24'd200);
                nack++;
                if (nack == 4) req = '0;
            end
        end
        check("contention_acks", 32'(nack), 4);
        for (int k = 0; k < 4; k++) check("contention_order", 32'(order[k]), 32'(k % 2));
        cyc = 0;
        while (sb.size() != 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("contention_drained", 32'(sb.size()), 0);

        // Reset in the middle of a multiply discards it.
        drive(0, 1'b1, 24'd100, 12'd100);
        @(negedge clk);
        check("rstrun_ack", 32'(ack), 1);
        req[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("rstrun_busy_before", 32'(busy), 1);
        do_reset();
        check("rstrun_res", 32'(res), 0);
        check("rstrun_busy", 32'(busy), 0);
        done_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done != 0) done_cnt++;
        end
        check("rstrun_no_done", 32'(done_cnt), 0);
        drive(1, 1'b0, 24'd999, 12'd3);
        @(negedge clk);
        check("rstrun_new_ack", 32'(ack), 2);
        check("rstrun_units_idle", 32'({dut.u_div.run, dut.u_mul.run}), 0);
        req[1] = 1'b0;
        push(1, 1'b1, 24'd333);
        wait_done(100, cyc);

        // Short req0 pulse while busy is withdrawn.
        ack0_before = ack_seen[0];
        drive(1, 1'b0, 24'd50000, 12'd7);
        @(negedge clk);
        check("wd_ack1", 32'(ack), 2);
        req[1] = 1'b0;
        push(1, 1'b1, 24'd7142);
        repeat (3) @(negedge clk);
        drive(0, 1'b1, 24'd5, 12'd5);
        @(negedge clk);
        req[0] = 1'b0;
        wait_done(100, cyc);
        repeat (5) @(negedge clk);
        check("wd_no_ack0", 32'(ack_seen[0] - ack0_before), 0);

        // Divide by zero.
        dstart_before = div_start_cnt;
        drive(0, 1'b0, 24'd500, 12'd0);
        @(negedge clk);
        check("dz_ack", 32'(ack), 1);
        req[0] = 1'b0;
`ifdef VIDEO_ARITH_DIVZERO_EN
        push(0, 1'b1, 24'hFFFFFF);
        wait_done(100, cyc);
        check("dz_latency", 32'(cyc), 1);
        check("dz_no_start", 32'(div_start_cnt - dstart_before), 0);
`else
        push(0, 1'b0, 24'h0);
        wait_done(100, cyc);
        check("dz_start_pulsed", 32'(div_start_cnt - dstart_before), 1);
`endif
        repeat (3) @(negedge clk);
        check("final_sb_empty", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
